// File: rtl/mux_rr_wide.sv
// Registered N:1 multiplexer. It arbitrates by round-robin or by a fixed select, with a
// valid/ready handshake on every input channel and on the output.
//
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   in_data[0:N-1]       per-channel data words
//   in_valid / in_ready  per-channel handshake; in_ready is one-hot or zero
//   mode, fixed_sel      0 = round-robin, 1 = use channel fixed_sel
//   out_data, out_sel    registered winner word and the index of its channel
//   out_valid/out_ready  output handshake; the one-entry register can refill on each drain
module mux_rr_wide #(
    parameter int WIDTH = 64,
    parameter int N     = 16,
    parameter int SELW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data [0:N-1],
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SELW-1:0]  fixed_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SELW-1:0]  out_sel
);

    localparam logic [SELW:0]   NW   = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N-1);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_idx;
    logic            rr_hit;
    logic            fix_hit;
    logic [SELW:0]   probe;
    logic [SELW-1:0] grant;
    logic            has_grant;
    logic            load_en;

    // Rotated find-first. Offsets are scanned from the highest down to the lowest,
    // so the smallest offset from ptr is the last one written and therefore wins.
    // The modulo-N wrap is done on a SELW+1 bit sum, so it also works for N that is
    // not a power of two.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        probe  = '0;
        for (int k = N-1; k >= 0; k--) begin
            probe = {1'b0, ptr} + (SELW+1)'(k);
            if (probe >= NW) begin
                probe = probe - NW;
            end
            if (in_valid[probe[SELW-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = probe[SELW-1:0];
            end
        end
    end

    // An out-of-range fixed_sel never grants.
    assign fix_hit   = ({1'b0, fixed_sel} < NW) && in_valid[fixed_sel];
    assign has_grant = mode ? fix_hit : rr_hit;
    assign grant     = mode ? fixed_sel : rr_idx;
    assign load_en   = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (has_grant && load_en && !reset) begin
            in_ready = N'(1) << grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            if (has_grant) begin
                out_data  <= in_data[grant];
                out_sel   <= grant;
                out_valid <= 1'b1;
                // In fixed mode ptr is left alone, so round-robin resumes where it stopped.
                if (!mode) begin
                    ptr <= (grant == LAST) ? '0 : grant + SELW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_wide.sv
// Scoreboard bench for mux_rr_wide with N=10, which is not a power of two.
// The driver predicts each word from a queue-level model and the monitor checks every output word.
module tb_mux_rr_wide;

    localparam int WIDTH = 64;
    localparam int N     = 10;
    localparam int SELW  = $clog2(N);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data [0:N-1];
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [SELW-1:0]  fixed_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SELW-1:0]  out_sel;

    mux_rr_wide #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .fixed_sel(fixed_sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  sel;
    } exp_t;

    exp_t sb[$];
    int   seen[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   m_ptr      = 0;
    bit   m_valid    = 1'b0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, taken modulo N.
    function automatic int model_grant();
        if (mode) begin
            if (int'(fixed_sel) < N && in_valid[fixed_sel]) return int'(fixed_sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c[SELW-1:0]]) return c;
        end
        return -1;
    endfunction

    // Inputs are set at posedge+1. The model is checked and updated at negedge+1.
    task automatic step();
        int         g;
        bit         le;
        logic [N-1:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        #1;
        le      = !m_valid || out_ready;
        g       = model_grant();
        exp_rdy = (g >= 0 && le) ? (N'(1) << g) : '0;
        chk("in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
        chk("out_valid", WIDTH'(out_valid), WIDTH'(m_valid));
        if (le) begin
            if (g >= 0) begin
                e.data = in_data[g];
                e.sel  = SELW'(g);
                sb.push_back(e);
                m_valid = 1'b1;
                if (!mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        reset   = 1'b0;
    endtask

    task automatic check_seen(input string name, input int exp[$]);
        chk({name, "_count"}, WIDTH'(seen.size()), WIDTH'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
            chk(name, WIDTH'(seen[i]), WIDTH'(exp[i]));
        end
    endtask

    // Monitor: checks every held word against the queue head and pops it on drain.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: sel %0d data %h, none expected",
                             out_sel, out_data);
                end else begin
                    chk("out_data", out_data, sb[0].data);
                    chk("out_sel", WIDTH'(out_sel), WIDTH'(sb[0].sel));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen.push_back(int'(out_sel));
                    end
                end
            end
        end
    end

    initial begin
        int exp[$];
        reset     = 1'b1;
        in_valid  = '1;
        mode      = 1'b0;
        fixed_sel = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = WIDTH'(i * 'h1111);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", WIDTH'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sel", WIDTH'(out_sel), '0);
        chk("rst_in_ready", WIDTH'(in_ready), '0);
        in_valid = '0;
        reset    = 1'b0;

        // Round-robin over all channels, including the wrap back to 0.
        in_valid = '1;
        seen.delete();
        repeat (12) step();
        exp = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        check_seen("rr_seq", exp);

        // Only the two end channels request: grants alternate 0, 9.
        do_reset();
        in_valid = '0;
        in_valid[0] = 1'b1;
        in_valid[N-1] = 1'b1;
        seen.delete();
        repeat (5) step();
        exp = {0, 9, 0, 9};
        check_seen("wrap_seq", exp);

        // Backpressure: the held word stays put and in_ready stays low.
        in_valid  = '1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        chk("bp_in_ready", WIDTH'(in_ready), '0);
        out_ready = 1'b1;
        repeat (2) step();

        // Fixed select.
        mode      = 1'b1;
        fixed_sel = SELW'(7);
        step();
        seen.delete();
        repeat (4) step();
        exp = {7, 7, 7, 7};
        check_seen("fixed_seq", exp);
        in_valid[7] = 1'b0;
        repeat (2) step();
        chk("fixed_idle_valid", WIDTH'(out_valid), '0);
        in_valid  = '1;
        fixed_sel = SELW'(15);
        step();
        chk("fixed_oor_ready", WIDTH'(in_ready), '0);
        chk("fixed_oor_valid", WIDTH'(out_valid), '0);

        // A mode switch keeps the round-robin pointer.
        mode     = 1'b0;
        in_valid = '0;
        in_valid[3] = 1'b1;
        seen.delete();
        step();
        mode      = 1'b1;
        fixed_sel = SELW'(7);
        in_valid  = '1;
        repeat (4) step();
        mode = 1'b0;
        repeat (3) step();
        exp = {3, 7, 7, 7, 7, 4, 5};
        check_seen("mode_switch", exp);

        // Reset in the middle of a cycle while a word is held.
        mode      = 1'b0;
        out_ready = 1'b0;
        in_valid  = '0;
        repeat (2) step();
        in_valid    = '0;
        in_valid[2] = 1'b1;
        in_data[2]  = 64'hA5;
        out_ready   = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = '0;
        chk("pre_rst_data", out_data, 64'hA5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", WIDTH'(out_valid), '0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_ready", WIDTH'(in_ready), '0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(negedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = '1;
        out_ready = 1'b1;
        seen.delete();
        repeat (2) step();
        exp = {0};
        check_seen("post_rst_ptr", exp);

        // Random traffic.
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) in_data[i] = {$urandom, $urandom};
            in_valid  = N'({$urandom, $urandom});
            out_ready = ($urandom_range(3) != 0);
            mode      = ($urandom_range(4) == 0);
            fixed_sel = SELW'($urandom_range(15));
            step();
        end

        // Drain, then confirm that no predicted word is still outstanding.
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("sb_drained", WIDTH'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
